// File: rtl/logic_unit_pkg.sv
// Shared opcode definitions for the logic unit pipeline.
package logic_unit_pkg;

    // ALU_FUNC encodings
    typedef enum logic [2:0] {
        FuncAnd   = 3'b000,
        FuncOr    = 3'b001,
        FuncNand  = 3'b010,
        FuncNor   = 3'b011,
        FuncXor   = 3'b100,
        FuncXnor  = 3'b101,
        FuncNotA  = 3'b110,
        FuncPassA = 3'b111
    } alu_func_e;

endpackage

// File: rtl/logic_unit_stage.sv
// One pipeline slot: valid/data/flags register with hold, load and flush.
// Parity bit exists only when LOGIC_UNIT_PIPE_PARITY_EN is defined.
module logic_unit_stage #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             i_flush,
    input  logic             i_load,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_zero,
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
    input  logic             i_parity,
    output logic             o_parity,
`endif
    output logic             o_valid,
    output logic [WIDTH-1:0] o_data,
    output logic             o_zero
);

    logic             r_valid;
    logic [WIDTH-1:0] r_data;
    logic             r_zero;
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
    logic             r_parity;
`endif

    // Flush beats load; load beats hold. Payload of an empty slot is don't-care.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_zero   <= 1'b0;
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else if (i_flush) begin
            r_valid  <= 1'b0;
        end else if (i_load) begin
            r_valid  <= i_valid;
            r_data   <= i_data;
            r_zero   <= i_zero;
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
            r_parity <= i_parity;
`endif
        end
    end

    assign o_valid  = r_valid;
    assign o_data   = r_data;
    assign o_zero   = r_zero;
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
    assign o_parity = r_parity;
`endif

endmodule

// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit with valid/ready handshake and global stall.
// Optional PARITY_FLAG output enabled by LOGIC_UNIT_PIPE_PARITY_EN.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             FLUSH,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALU_FUNC,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] LOGIC_OUT,
    output logic             ZERO_FLAG
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
    ,
    output logic             PARITY_FLAG
`endif
);

    logic                          w_advance;
    logic                          w_accept;
    logic [WIDTH-1:0]              w_result;
    // Index 0 is the stage-1 input; index STAGES is the output stage.
    logic [STAGES:0]               w_valid;
    logic [STAGES:0][WIDTH-1:0]    w_data;
    logic [STAGES:0]               w_zero;
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
    logic [STAGES:0]               w_parity;
`endif

    // All stages move together; a full output stage not being taken stalls everything.
    assign w_advance = !w_valid[STAGES] || OUT_READY;
    assign IN_READY  = w_advance && !FLUSH;
    assign w_accept  = IN_VALID && IN_READY;

    // Operation decode
    always_comb begin
        w_result = '0;
        unique case (alu_func_e'(ALU_FUNC))
            FuncAnd:   w_result = A & B;
            FuncOr:    w_result = A | B;
            FuncNand:  w_result = ~(A & B);
            FuncNor:   w_result = ~(A | B);
            FuncXor:   w_result = A ^ B;
            FuncXnor:  w_result = ~(A ^ B);
            FuncNotA:  w_result = ~A;
            FuncPassA: w_result = A;
        endcase
    end

    assign w_valid[0]  = w_accept;
    assign w_data[0]   = w_result;
    assign w_zero[0]   = (w_result == '0);
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
    assign w_parity[0] = ^w_result;
`endif

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            logic_unit_stage #(
                .WIDTH(WIDTH)
            ) u_stage (
                .CLK     (CLK),
                .RST     (RST),
                .i_flush (FLUSH),
                .i_load  (w_advance),
                .i_valid (w_valid[gi]),
                .i_data  (w_data[gi]),
                .i_zero  (w_zero[gi]),
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
                .i_parity(w_parity[gi]),
                .o_parity(w_parity[gi+1]),
`endif
                .o_valid (w_valid[gi+1]),
                .o_data  (w_data[gi+1]),
                .o_zero  (w_zero[gi+1])
            );
        end
    endgenerate

    // Outputs read zero whenever no result is presented.
    assign OUT_VALID   = w_valid[STAGES];
    assign LOGIC_OUT   = OUT_VALID ? w_data[STAGES] : '0;
    assign ZERO_FLAG   = OUT_VALID && w_zero[STAGES];
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
    assign PARITY_FLAG = OUT_VALID && w_parity[STAGES];
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Scoreboard bench for logic_unit_pipe: main DUT (16b/2 stages) plus
// 1b/1 stage and 16b/4 stage instances. Parity checks need LOGIC_UNIT_PIPE_PARITY_EN.
module tb_logic_unit_pipe;

    typedef struct {
        logic [63:0] data;
        logic        zero;
        logic        par;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        out_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic [2:0]  func;

    logic        m_ir, m_ov, m_zf, m_pf;
    logic [15:0] m_dout;
    logic        s1_ir, s1_ov, s1_zf, s1_pf;
    logic [0:0]  s1_dout;
    logic        s4_ir, s4_ov, s4_zf, s4_pf;
    logic [15:0] s4_dout;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    exp_t        sb[3][$];

    logic        prev_hold  = 1'b0;
    logic        prev_flush = 1'b0;
    logic [15:0] prev_dout  = '0;
    logic        prev_zf    = 1'b0;

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(16), .STAGES(2)) u_dut (
        .CLK(clk), .RST(rst_n), .FLUSH(flush), .IN_VALID(in_valid), .IN_READY(m_ir),
        .A(a[15:0]), .B(b[15:0]), .ALU_FUNC(func), .OUT_VALID(m_ov), .OUT_READY(out_ready),
        .LOGIC_OUT(m_dout), .ZERO_FLAG(m_zf)
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
        , .PARITY_FLAG(m_pf)
`endif
    );

    logic_unit_pipe #(.WIDTH(1), .STAGES(1)) u_dut_s1 (
        .CLK(clk), .RST(rst_n), .FLUSH(flush), .IN_VALID(in_valid), .IN_READY(s1_ir),
        .A(a[0:0]), .B(b[0:0]), .ALU_FUNC(func), .OUT_VALID(s1_ov), .OUT_READY(1'b1),
        .LOGIC_OUT(s1_dout), .ZERO_FLAG(s1_zf)
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
        , .PARITY_FLAG(s1_pf)
`endif
    );

    logic_unit_pipe #(.WIDTH(16), .STAGES(4)) u_dut_s4 (
        .CLK(clk), .RST(rst_n), .FLUSH(flush), .IN_VALID(in_valid), .IN_READY(s4_ir),
        .A(a[15:0]), .B(b[15:0]), .ALU_FUNC(func), .OUT_VALID(s4_ov), .OUT_READY(1'b1),
        .LOGIC_OUT(s4_dout), .ZERO_FLAG(s4_zf)
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
        , .PARITY_FLAG(s4_pf)
`endif
    );

`ifndef LOGIC_UNIT_PIPE_PARITY_EN
    assign m_pf  = 1'b0;
    assign s1_pf = 1'b0;
    assign s4_pf = 1'b0;
`endif

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic exp_t model(input logic [2:0] f, input logic [63:0] x,
                                   input logic [63:0] y, input int w);
        exp_t        e;
        logic [63:0] r;
        logic [63:0] m;
        m = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        case (f)
            3'b000:  r = x & y;
            3'b001:  r = x | y;
            3'b010:  r = ~(x & y);
            3'b011:  r = ~(x | y);
            3'b100:  r = x ^ y;
            3'b101:  r = ~(x ^ y);
            3'b110:  r = ~x;
            default: r = x;
        endcase
        r      = r & m;
        e.data = r;
        e.zero = (r == 64'd0);
        e.par  = ^r;
        return e;
    endfunction

    // Per-DUT scoreboard step at the falling edge: pop on transfer, push on accept.
    task automatic mon(input int idx, input int w, input logic ov, input logic [63:0] dout,
                       input logic zf, input logic pf, input logic irdy, input logic ordy);
        exp_t e;
        if (ov && ordy) begin
            if (sb[idx].size() == 0) begin
                check($sformatf("s%0d_extra_beat", idx), 64'(ov), 64'd0);
            end else begin
                e = sb[idx].pop_front();
                check($sformatf("s%0d_data", idx), dout, e.data);
                check($sformatf("s%0d_zero", idx), 64'(zf), 64'(e.zero));
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
                check($sformatf("s%0d_parity", idx), 64'(pf), 64'(e.par));
`endif
            end
        end
        if (!ov) begin
            check($sformatf("s%0d_idle_data", idx), dout, 64'd0);
            check($sformatf("s%0d_idle_zero", idx), 64'(zf), 64'd0);
            check($sformatf("s%0d_idle_parity", idx), 64'(pf), 64'd0);
        end
        if (flush) sb[idx].delete();
        if (in_valid && irdy) sb[idx].push_back(model(func, a, b, w));
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) sb[i].delete();
            prev_hold = 1'b0;
        end else begin
            check("in_ready", 64'(m_ir), 64'((!m_ov || out_ready) && !flush));
            if (prev_hold && !prev_flush) begin
                check("hold_data", 64'(m_dout), 64'(prev_dout));
                check("hold_zero", 64'(m_zf), 64'(prev_zf));
            end
            prev_hold  = m_ov && !out_ready;
            prev_flush = flush;
            prev_dout  = m_dout;
            prev_zf    = m_zf;
            mon(0, 16, m_ov, 64'(m_dout), m_zf, m_pf, m_ir, out_ready);
            mon(1, 1, s1_ov, 64'(s1_dout), s1_zf, s1_pf, s1_ir, 1'b1);
            mon(2, 16, s4_ov, 64'(s4_dout), s4_zf, s4_pf, s4_ir, 1'b1);
        end
    end

    // Present a beat and hold it until the main DUT takes it.
    task automatic send(input logic [63:0] ta, input logic [63:0] tb, input logic [2:0] tf);
        a        = ta;
        b        = tb;
        func     = tf;
        in_valid = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (m_ir) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
        end
        check("send_timeout", 64'(m_ir), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 40 && (sb[0].size() + sb[1].size() + sb[2].size()) != 0; t++)
            @(posedge clk);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++)
            check($sformatf("%s_q%0d_empty", tag, i), 64'(sb[i].size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; func = 3'b000;
        #12;
        check("rst_out_valid", 64'(m_ov), 64'd0);
        check("rst_logic_out", 64'(m_dout), 64'd0);
        check("rst_zero", 64'(m_zf), 64'd0);
        check("rst_parity", 64'(m_pf), 64'd0);
        check("rst_in_ready", 64'(m_ir), 64'd1);
        @(posedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;

        // XOR example: two-cycle latency
        a = 64'hF0F0; b = 64'h0FF0; func = 3'b100; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("lat1_out_valid", 64'(m_ov), 64'd0);
        @(posedge clk); #1;
        check("lat2_out_valid", 64'(m_ov), 64'd1);
        check("xor_logic_out", 64'(m_dout), 64'hFF00);
        check("xor_zero", 64'(m_zf), 64'd0);

        // AND to zero
        a = 64'h00FF; b = 64'hFF00; func = 3'b000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("and_out_valid", 64'(m_ov), 64'd1);
        check("and_logic_out", 64'(m_dout), 64'h0000);
        check("and_zero", 64'(m_zf), 64'd1);
`ifdef LOGIC_UNIT_PIPE_PARITY_EN
        check("and_parity", 64'(m_pf), 64'd0);
`endif
        idle(2);

        // Opcode sweep, random operands, back-to-back
        for (int f = 0; f < 8; f++)
            for (int k = 0; k < 4; k++)
                send({$urandom, $urandom}, {$urandom, $urandom}, 3'(f));
        drain("sweep");

        // Backpressure mid-stream
        fork
            begin
                for (int i = 0; i < 4; i++)
                    send({$urandom, $urandom}, {$urandom, $urandom}, 3'(i + 1));
            end
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                @(negedge clk);
                check("stall_out_valid", 64'(m_ov), 64'd1);
                check("stall_in_ready", 64'(m_ir), 64'd0);
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain("stall");

        // Flush with two beats in flight and a beat offered
        out_ready = 1'b0;
        send(64'h1234, 64'h5678, 3'b001);
        send(64'hAAAA, 64'h5555, 3'b100);
        check("flush_setup_ov", 64'(m_ov), 64'd1);
        a = 64'hBEEF; b = 64'h0000; func = 3'b111; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_out_valid", 64'(m_ov), 64'd0);
        out_ready = 1'b1;
        idle(6);
        drain("flush");

        // Asynchronous reset mid-cycle with a result presented
        out_ready = 1'b0;
        send(64'h0F0F, 64'h00FF, 3'b001);
        for (int t = 0; t < 10 && !m_ov; t++) begin
            @(posedge clk); #1;
        end
        check("arst_setup_ov", 64'(m_ov), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(m_ov), 64'd0);
        check("arst_logic_out", 64'(m_dout), 64'd0);
        check("arst_zero", 64'(m_zf), 64'd0);
        check("arst_s4_valid", 64'(s4_ov), 64'd0);
        out_ready = 1'b1;
        @(posedge clk); #2 rst_n = 1'b1;
        check("arst_in_ready", 64'(m_ir), 64'd1);
        a = 64'h3C3C; b = 64'hFFFF; func = 3'b101; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("resume_out_valid", 64'(m_ov), 64'd1);
        check("resume_logic_out", 64'(m_dout), 64'h3C3C);
        drain("reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
